// File: rtl/obb_state_bank.sv
// Double-buffered state store for up to N_OBJ oriented bounding boxes.
// Each frame it walks the slots through the external OBB updater.
module obb_state_bank #(
    parameter int N_OBJ = 8,
    parameter int IDX_W = $clog2(N_OBJ),
    parameter int OBB_W = 128
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             frame_tick_i,
    input  logic             load_en_i,
    input  logic [IDX_W-1:0] load_idx_i,
    input  logic [OBB_W-1:0] load_obb_i,
    input  logic             load_active_i,
    output logic [OBB_W-1:0] upd_prev_o,
    input  logic [OBB_W-1:0] upd_next_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [OBB_W-1:0] rd_obb_o,
    output logic             rd_active_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o,
    output logic             load_drop_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_COMMIT
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

    logic [OBB_W-1:0] bank_q [2][N_OBJ];
    logic [N_OBJ-1:0] active_q;
    logic             front_q,     front_d;
    state_e           state_q,     state_d;
    logic [IDX_W-1:0] cur_idx_q,   cur_idx_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             overrun_q,   overrun_d;
    logic             load_drop_q, load_drop_d;
    logic             run_we;
    logic             load_we;
    logic [OBB_W-1:0] run_wdata;

    assign upd_prev_o  = bank_q[front_q][cur_idx_q];
    assign rd_obb_o    = bank_q[front_q][rd_idx_i];
    assign rd_active_o = active_q[rd_idx_i];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;
    assign load_drop_o = load_drop_q;

    // Inactive slots are copied through so the back bank is always a full frame.
    assign run_wdata = active_q[cur_idx_q] ? upd_next_i : upd_prev_o;

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        front_d     = front_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q | (frame_tick_i & busy_q);
        load_drop_d = load_drop_q | (load_en_i & busy_q);
        run_we      = 1'b0;
        load_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_we = load_en_i;
                if (frame_tick_i) begin
                    state_d   = ST_RUN;
                    cur_idx_d = '0;
                end
            end
            ST_RUN: begin
                run_we    = 1'b1;
                cur_idx_d = cur_idx_q + IDX_W'(1);
                if (cur_idx_q == LAST_IDX) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                front_d   = ~front_q;
                done_d    = 1'b1;
                cur_idx_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                cur_idx_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            active_q    <= '0;
            front_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cur_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            load_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            front_q     <= front_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            load_drop_q <= load_drop_d;
            // Host loads land in both banks so the next pass sees them regardless of front.
            if (load_we) begin
                bank_q[0][load_idx_i] <= load_obb_i;
                bank_q[1][load_idx_i] <= load_obb_i;
                active_q[load_idx_i]  <= load_active_i;
            end
            if (run_we) begin
                bank_q[~front_q][cur_idx_q] <= run_wdata;
            end
        end
    end

endmodule

// File: tb/tb_obb_state_bank.sv
// Self-checking bench for obb_state_bank: table vectors, hand sequences and
// randomized passes compared against a frame-level model of the bank.
`timescale 1ns/1ps
module tb_obb_state_bank;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int W  = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [W-1:0]  load_obb;
    logic          load_active;
    logic [W-1:0]  upd_prev;
    logic [W-1:0]  upd_next;
    logic [IW-1:0] rd_idx;
    logic [W-1:0]  rd_obb;
    logic          rd_active;
    logic          busy;
    logic          done;
    logic          overrun;
    logic          load_drop;

    int vecCount = 0;
    int errCount = 0;

    // Model: the frame readers should see, per-slot active bits, sticky flags.
    logic [W-1:0] mBank [N];
    logic         mActive [N];
    logic         mOverrun;
    logic         mDrop;

    typedef struct {
        int           idx;
        logic [W-1:0] val;
        logic         act;
        logic [W-1:0] expAfter;
    } vec_t;

    // Free-running clock, 20 ns period.
    always #10 clk = ~clk;

    // Updater stand-in: next = prev + 1.
    assign upd_next = upd_prev + 128'd1;

    obb_state_bank #(.N_OBJ(N), .IDX_W(IW), .OBB_W(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .frame_tick_i (frame_tick),
        .load_en_i    (load_en),
        .load_idx_i   (load_idx),
        .load_obb_i   (load_obb),
        .load_active_i(load_active),
        .upd_prev_o   (upd_prev),
        .upd_next_i   (upd_next),
        .rd_idx_i     (rd_idx),
        .rd_obb_o     (rd_obb),
        .rd_active_o  (rd_active),
        .busy_o       (busy),
        .done_o       (done),
        .overrun_o    (overrun),
        .load_drop_o  (load_drop)
    );

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        frame_tick  = 1'b0;
        load_en     = 1'b0;
        load_idx    = '0;
        load_obb    = '0;
        load_active = 1'b0;
    endtask

    task automatic modelClear();
        for (int i = 0; i < N; i++) begin
            mBank[i]   = '0;
            mActive[i] = 1'b0;
        end
        mOverrun = 1'b0;
        mDrop    = 1'b0;
    endtask

    task automatic applyReset();
        idleInputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        modelClear();
    endtask

    // Walks every slot through rd_idx and compares against the model frame.
    task automatic checkOutput(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = IW'(i);
            #1;
            checkVal($sformatf("%s rd_obb[%0d]", tag, i), rd_obb, mBank[i]);
            checkVal($sformatf("%s rd_active[%0d]", tag, i), W'(rd_active), W'(mActive[i]));
        end
        checkVal({tag, " busy"}, W'(busy), '0);
        checkVal({tag, " overrun"}, W'(overrun), W'(mOverrun));
        checkVal({tag, " load_drop"}, W'(load_drop), W'(mDrop));
    endtask

    task automatic applyLoad(input int idx, input logic [W-1:0] val, input logic act);
        load_en     = 1'b1;
        load_idx    = IW'(idx);
        load_obb    = val;
        load_active = act;
        step();
        idleInputs();
        mBank[idx]   = val;
        mActive[idx] = act;
    endtask

    // One pass, checked cycle by cycle. Cycle c counts edges since the tick was sampled:
    // c=1..N are RUN (cur_idx=c-1), c=N+1 is COMMIT, c=N+2 is the done cycle.
    task automatic runPass(input bit coLoad, input int ci, input logic [W-1:0] cv, input logic ca,
                           input int midTick, input int midLoad, input int watchIdx);
        logic [W-1:0] oldF [N];
        logic [W-1:0] newF [N];
        if (coLoad) begin
            load_en     = 1'b1;
            load_idx    = IW'(ci);
            load_obb    = cv;
            load_active = ca;
            mBank[ci]   = cv;
            mActive[ci] = ca;
        end
        for (int i = 0; i < N; i++) begin
            oldF[i] = mBank[i];
            newF[i] = mActive[i] ? mBank[i] + 128'd1 : mBank[i];
        end
        rd_idx     = IW'(watchIdx);
        frame_tick = 1'b1;
        step();
        for (int c = 1; c <= N + 4; c++) begin
            if (c <= N) begin
                checkVal($sformatf("upd_prev c%0d", c), upd_prev, oldF[c-1]);
            end
            checkVal($sformatf("busy c%0d", c), W'(busy), W'(c <= N + 1));
            checkVal($sformatf("done c%0d", c), W'(done), W'(c == N + 2));
            checkVal($sformatf("rd_obb hold c%0d", c), rd_obb,
                     (c >= N + 2) ? newF[watchIdx] : oldF[watchIdx]);
            idleInputs();
            if (c == midTick) begin
                frame_tick = 1'b1;
                if (c <= N + 1) mOverrun = 1'b1;
            end
            if (c == midLoad) begin
                load_en     = 1'b1;
                load_idx    = IW'(watchIdx);
                load_obb    = ~oldF[watchIdx];
                load_active = ~mActive[watchIdx];
                if (c <= N + 1) mDrop = 1'b1;
            end
            step();
        end
        idleInputs();
        mBank = newF;
    endtask

    // Random loads followed by a pass with random mid-pass disturbances.
    task automatic applyStimulus(input int iters);
        for (int it = 0; it < iters; it++) begin
            int nLoads;
            nLoads = int'($urandom_range(1, 3));
            for (int k = 0; k < nLoads; k++) begin
                applyLoad(int'($urandom_range(0, N - 1)),
                          {$urandom(), $urandom(), $urandom(), $urandom()},
                          1'($urandom_range(0, 1)));
            end
            runPass(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, N + 1)), int'($urandom_range(0, N + 1)),
                    int'($urandom_range(0, N - 1)));
            checkOutput($sformatf("rand%0d", it));
        end
    endtask

    initial begin
        vec_t tbl [4];
        tbl[0] = '{3, 128'd5, 1'b1, 128'd6};
        tbl[1] = '{1, 128'd7, 1'b0, 128'd7};
        tbl[2] = '{6, {W{1'b1}}, 1'b1, 128'd0};
        tbl[3] = '{5, 128'h1234, 1'b1, 128'h1235};

        idleInputs();
        rd_idx = '0;
        reset  = 1'b1;
        step();
        applyReset();
        checkVal("reset upd_prev", upd_prev, '0);
        checkVal("reset done", W'(done), '0);
        checkOutput("reset");

        // Table: load one slot, run a pass, check that slot and the whole frame.
        for (int v = 0; v < 4; v++) begin
            applyLoad(tbl[v].idx, tbl[v].val, tbl[v].act);
            runPass(1'b0, 0, '0, 1'b0, 0, 0, tbl[v].idx);
            rd_idx = IW'(tbl[v].idx);
            #1;
            checkVal($sformatf("tbl%0d rd_obb", v), rd_obb, tbl[v].expAfter);
            checkOutput($sformatf("tbl%0d", v));
        end

        // Second tick 3 cycles in plus a dropped load on the watched slot.
        runPass(1'b0, 0, '0, 1'b0, 3, 5, 3);
        checkOutput("overrun");

        // Load and tick in the same idle cycle: pass sees the loaded value.
        runPass(1'b1, 0, 128'd9, 1'b1, 0, 0, 0);
        rd_idx = '0;
        #1;
        checkVal("coload rd_obb[0]", rd_obb, 128'd10);

        // Reset four cycles into a pass.
        frame_tick = 1'b1;
        step();
        idleInputs();
        for (int c = 1; c < 4; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        modelClear();
        checkVal("midreset done", W'(done), '0);
        checkOutput("midreset");
        applyLoad(2, 128'd40, 1'b1);
        runPass(1'b0, 0, '0, 1'b0, 0, 0, 2);
        checkOutput("postreset");

        applyReset();
        applyStimulus(8);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
